// File: rtl/prf_sliced_read_pkg.sv
// Shared types and constants for the byte-sliced physical register file.
// Slice numbering, stagger latencies, the write packet and the init FSM
// state type live here so the top and the slice banks agree on them.
package prf_sliced_read_pkg;

    // Default geometry; the top's parameters default to these values.
    localparam int PRF_DEPTH    = 96;
    localparam int PRF_ADDR_W   = 7;
    localparam int PRF_SLICE_W  = 8;
    localparam int PRF_WR_PORTS = 2;

    localparam int NUM_SLICES = 4;
    localparam int SLICE0     = 0;
    localparam int SLICE1     = 1;
    localparam int SLICE2     = 2;
    localparam int SLICE3     = 3;

    // Cycles from read issue to the slice appearing on its output.
    localparam int RD_LAT_S0  = 1;
    localparam int RD_LAT_S1  = 2;
    localparam int RD_LAT_S23 = 3;

    // Write request as accepted at the file boundary (already gated by ready).
    // Sized by the package geometry; the top must be built with matching widths.
    typedef struct packed {
        logic                                valid;
        logic [PRF_ADDR_W-1:0]               addr;
        logic [NUM_SLICES*PRF_SLICE_W-1:0]   data;
    } prfWrPkt;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } prf_state_e;

endpackage

// File: rtl/prf_slice_bank.sv
// One byte-wide slice of the register file: DEPTH entries, one combinational
// read port, WR_PORTS write ports plus a clear port used by the init sweep.
// Same-cycle writes to one address resolve to the highest port index.
module prf_slice_bank #(
    parameter int DEPTH    = 96,
    parameter int ADDR_W   = 7,
    parameter int SLICE_W  = 8,
    parameter int WR_PORTS = 2
) (
    input  logic                               clk,
    input  logic [WR_PORTS-1:0]                we,
    input  logic [WR_PORTS-1:0][ADDR_W-1:0]    waddr,
    input  logic [WR_PORTS-1:0][SLICE_W-1:0]   wdata,
    input  logic                               clr_en,
    input  logic [ADDR_W-1:0]                  clr_addr,
    input  logic [ADDR_W-1:0]                  raddr,
    output logic [SLICE_W-1:0]                 rdata
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    logic [SLICE_W-1:0] mem [DEPTH];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    // Array update: clear first, then ports in ascending order so the last
    // non-blocking assignment (highest port) wins. Out-of-range writes drop.
    always_ff @(posedge clk) begin
        if (clr_en && in_range(clr_addr))
            mem[clr_addr] <= '0;
        for (int p = 0; p < WR_PORTS; p++) begin
            if (we[p] && in_range(waddr[p]))
                mem[waddr[p]] <= wdata[p];
        end
    end

    // Asynchronous read; out-of-range addresses read as zero.
    always_comb begin
        rdata = '0;
        if (in_range(raddr))
            rdata = mem[raddr];
    end

endmodule

// File: rtl/prf_sliced_read.sv
// Byte-sliced physical register file feeding the RegRead bypass stage.
// Slice 0 and the tag come out one cycle after the read, slice 1 one cycle
// later, slices 2/3 one cycle after that. Writes are staggered the same way
// so every slice observes identical write-before-read ordering.
// Optional build macro: PRF_INIT_CLEAR_EN (zero the array after reset).
module prf_sliced_read
    import prf_sliced_read_pkg::*;
#(
    parameter int DEPTH    = PRF_DEPTH,
    parameter int ADDR_W   = PRF_ADDR_W,
    parameter int SLICE_W  = PRF_SLICE_W,
    parameter int WR_PORTS = PRF_WR_PORTS
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                rdEn_i,
    input  logic [ADDR_W-1:0]                   rdAddr_i,
    input  logic [WR_PORTS-1:0]                 wrEn_i,
    input  logic [WR_PORTS-1:0][ADDR_W-1:0]     wrAddr_i,
    input  logic [WR_PORTS-1:0][4*SLICE_W-1:0]  wrData_i,
    output logic                                rdValid_o,
    output logic [ADDR_W-1:0]                   rdTag_o,
    output logic [SLICE_W-1:0]                  datastage0_o,
    output logic [SLICE_W-1:0]                  datastage1_o,
    output logic [SLICE_W-1:0]                  datastage2_o,
    output logic [SLICE_W-1:0]                  datastage3_o,
    output logic                                ready_o
);

    localparam int STAGES = RD_LAT_S23 - 1;

    // Read side: stage k holds a read issued k cycles ago.
    logic                           rd_go;
    logic [STAGES:1]                vld_pipe;
    logic [STAGES:1][ADDR_W-1:0]    rd_addr_pipe;

    // Write side: two-deep per-port pipeline carrying the not-yet-written slices.
    prfWrPkt                             wr_pkt [WR_PORTS];
    logic [WR_PORTS-1:0]                 wp1_vld, wp2_vld;
    logic [WR_PORTS-1:0][ADDR_W-1:0]     wp1_addr, wp2_addr;
    logic [WR_PORTS-1:0][3*SLICE_W-1:0]  wp1_data;
    logic [WR_PORTS-1:0][2*SLICE_W-1:0]  wp2_data;

    logic [NUM_SLICES-1:0][WR_PORTS-1:0]               bank_we;
    logic [NUM_SLICES-1:0][WR_PORTS-1:0][ADDR_W-1:0]   bank_waddr;
    logic [NUM_SLICES-1:0][WR_PORTS-1:0][SLICE_W-1:0]  bank_wdata;
    logic [NUM_SLICES-1:0][ADDR_W-1:0]                 bank_raddr;
    logic [NUM_SLICES-1:0][SLICE_W-1:0]                bank_rdata;

    logic                clr_en;
    logic [ADDR_W-1:0]   clr_addr;

`ifdef PRF_INIT_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    prf_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;

    // Init FSM state and sweep counter; reset always restarts the sweep.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep one address per cycle, then hand the file over to normal traffic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_en  = 1'b0;
        case (state_q)
            ST_INIT: begin
                clr_en = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
    end

    assign clr_addr = cnt_q;
    assign ready_o  = (state_q == ST_RUN);
`else
    assign clr_en   = 1'b0;
    assign clr_addr = '0;

    // Ready rises on the first clock after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ready_o <= 1'b0;
        else        ready_o <= 1'b1;
    end
`endif

    assign rd_go = rdEn_i & ready_o;

    // Gate write requests by ready and bundle them per port.
    always_comb begin
        for (int p = 0; p < WR_PORTS; p++) begin
            wr_pkt[p].valid = wrEn_i[p] & ready_o;
            wr_pkt[p].addr  = wrAddr_i[p];
            wr_pkt[p].data  = wrData_i[p];
        end
    end

    // Read address/valid pipeline; addresses only advance with a valid read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe     <= '0;
            rd_addr_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_go;
            if (rd_go) rd_addr_pipe[1] <= rdAddr_i;
            for (int k = 2; k <= STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (vld_pipe[k-1]) rd_addr_pipe[k] <= rd_addr_pipe[k-1];
            end
        end
    end

    // Write pipeline: slice 1 lands one cycle after slice 0, slices 2/3 two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp1_vld  <= '0;
            wp2_vld  <= '0;
            wp1_addr <= '0;
            wp2_addr <= '0;
            wp1_data <= '0;
            wp2_data <= '0;
        end else begin
            for (int p = 0; p < WR_PORTS; p++) begin
                wp1_vld[p] <= wr_pkt[p].valid;
                if (wr_pkt[p].valid) begin
                    wp1_addr[p] <= wr_pkt[p].addr;
                    wp1_data[p] <= wr_pkt[p].data[4*SLICE_W-1:SLICE_W];
                end
                wp2_vld[p] <= wp1_vld[p];
                if (wp1_vld[p]) begin
                    wp2_addr[p] <= wp1_addr[p];
                    wp2_data[p] <= wp1_data[p][3*SLICE_W-1:SLICE_W];
                end
            end
        end
    end

    // Route each pipeline stage to the slice it feeds.
    always_comb begin
        bank_we    = '0;
        bank_waddr = '0;
        bank_wdata = '0;
        for (int p = 0; p < WR_PORTS; p++) begin
            bank_we[SLICE0][p]    = wr_pkt[p].valid;
            bank_waddr[SLICE0][p] = wr_pkt[p].addr;
            bank_wdata[SLICE0][p] = wr_pkt[p].data[SLICE_W-1:0];
            bank_we[SLICE1][p]    = wp1_vld[p];
            bank_waddr[SLICE1][p] = wp1_addr[p];
            bank_wdata[SLICE1][p] = wp1_data[p][SLICE_W-1:0];
            bank_we[SLICE2][p]    = wp2_vld[p];
            bank_waddr[SLICE2][p] = wp2_addr[p];
            bank_wdata[SLICE2][p] = wp2_data[p][SLICE_W-1:0];
            bank_we[SLICE3][p]    = wp2_vld[p];
            bank_waddr[SLICE3][p] = wp2_addr[p];
            bank_wdata[SLICE3][p] = wp2_data[p][2*SLICE_W-1:SLICE_W];
        end
        bank_raddr[SLICE0] = rdAddr_i;
        bank_raddr[SLICE1] = rd_addr_pipe[RD_LAT_S1-1];
        bank_raddr[SLICE2] = rd_addr_pipe[RD_LAT_S23-1];
        bank_raddr[SLICE3] = rd_addr_pipe[RD_LAT_S23-1];
    end

    for (genvar s = 0; s < NUM_SLICES; s++) begin : g_slice
        prf_slice_bank #(
            .DEPTH    (DEPTH),
            .ADDR_W   (ADDR_W),
            .SLICE_W  (SLICE_W),
            .WR_PORTS (WR_PORTS)
        ) u_bank (
            .clk      (clk),
            .we       (bank_we[s]),
            .waddr    (bank_waddr[s]),
            .wdata    (bank_wdata[s]),
            .clr_en   (clr_en),
            .clr_addr (clr_addr),
            .raddr    (bank_raddr[s]),
            .rdata    (bank_rdata[s])
        );
    end

    // Output data registers; each holds unless its pipelined read is valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            datastage0_o <= '0;
            datastage1_o <= '0;
            datastage2_o <= '0;
            datastage3_o <= '0;
        end else begin
            if (rd_go)                   datastage0_o <= bank_rdata[SLICE0];
            if (vld_pipe[RD_LAT_S1-1])   datastage1_o <= bank_rdata[SLICE1];
            if (vld_pipe[RD_LAT_S23-1]) begin
                datastage2_o <= bank_rdata[SLICE2];
                datastage3_o <= bank_rdata[SLICE3];
            end
        end
    end

    assign rdValid_o = vld_pipe[RD_LAT_S0];
    assign rdTag_o   = rd_addr_pipe[RD_LAT_S0];

endmodule
